// File: rtl/trace_line_checker.sv
// Character-serial checker for CPU trace lines: parses register-write and
// memory-write records, flags semantic errors and keeps saturating statistics.
module trace_line_checker #(
    parameter int          TIME_DIG  = 4,
    parameter int          GRF_DIG   = 4,
    parameter int          NUM_REGS  = 32,
    parameter logic [31:0] PC_LO     = 32'h0000_3000,
    parameter logic [31:0] PC_HI     = 32'h0000_6ffc,
    parameter logic [31:0] ADDR_HI   = 32'h0000_2ffc,
    parameter bit          HEX_UPPER = 1'b0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic             rec_valid,
    output logic [CNT_W-1:0] rec_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int          TW         = $clog2(10 ** TIME_DIG);
    localparam int          GW         = $clog2(10 ** GRF_DIG);
    localparam logic [7:0]  TIME_MAX   = 8'(TIME_DIG);
    localparam logic [7:0]  GRF_MAX    = 8'(GRF_DIG);
    localparam logic [7:0]  HEX_LEN    = 8'd8;
    localparam logic [31:0] NUM_REGS_W = 32'(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, TIME, AT, PC, COLON, SP1, GRF, ADDR, SP2, EQ, SP3, DATA, HASH, DONE
    } state_t;

    state_t          state;
    logic [7:0]      cnt;
    logic [TW-1:0]   time_acc;
    logic [GW-1:0]   grf_acc;
    logic [31:0]     pc_acc;
    logic [31:0]     addr_acc;
    logic            is_mem;

    logic            is_dec;
    logic            is_hex;
    logic [3:0]      digit;
    logic [TW-1:0]   time_next;
    logic [GW-1:0]   grf_next;
    logic [31:0]     time_mask;
    logic [3:0]      err_next;

    // Character classification, accumulator next values and the error vector
    // of the record that would complete on this edge.
    always_comb begin
        is_dec    = (char >= "0") && (char <= "9");
        is_hex    = is_dec || ((char >= "a") && (char <= "f"))
                  || (HEX_UPPER && (char >= "A") && (char <= "F"));
        digit     = is_dec ? char[3:0] : char[3:0] + 4'd9;
        time_next = (time_acc << 3) + (time_acc << 1) + TW'(digit);
        grf_next  = (grf_acc << 3) + (grf_acc << 1) + GW'(digit);
        time_mask = 32'(freq >> 1) - 32'd1;
        err_next    = 4'd0;
        err_next[0] = (32'(time_acc) & time_mask) != 32'd0;
        err_next[1] = (pc_acc < PC_LO) || (pc_acc > PC_HI) || (pc_acc[1:0] != 2'd0);
        err_next[2] = is_mem && ((addr_acc > ADDR_HI) || (addr_acc[1:0] != 2'd0));
        err_next[3] = !is_mem && (32'(grf_acc) >= NUM_REGS_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            time_acc    <= '0;
            grf_acc     <= '0;
            pc_acc      <= '0;
            addr_acc    <= '0;
            is_mem      <= 1'b0;
            format_type <= 2'd0;
            error_code  <= 4'd0;
            rec_valid   <= 1'b0;
            rec_count   <= '0;
            err_count   <= '0;
        end else begin
            format_type <= 2'd0;
            error_code  <= 4'd0;
            rec_valid   <= 1'b0;
            state       <= IDLE;
            // A caret always restarts a record, whatever was in progress.
            if (char == "^") begin
                state    <= TIME;
                cnt      <= '0;
                time_acc <= '0;
                grf_acc  <= '0;
                pc_acc   <= '0;
                addr_acc <= '0;
                is_mem   <= 1'b0;
            end else begin
                case (state)
                    TIME: begin
                        if (is_dec && (cnt < TIME_MAX)) begin
                            time_acc <= time_next;
                            cnt      <= cnt + 8'd1;
                            state    <= TIME;
                        end else if ((char == "@") && (cnt != 8'd0)) begin
                            state <= AT;
                        end
                    end
                    AT: begin
                        if (is_hex) begin
                            pc_acc <= {pc_acc[27:0], digit};
                            cnt    <= 8'd1;
                            state  <= PC;
                        end
                    end
                    PC: begin
                        if (is_hex && (cnt < HEX_LEN)) begin
                            pc_acc <= {pc_acc[27:0], digit};
                            cnt    <= cnt + 8'd1;
                            state  <= PC;
                        end else if ((char == ":") && (cnt == HEX_LEN)) begin
                            state <= COLON;
                        end
                    end
                    COLON, SP1: begin
                        if (char == " ") begin
                            state <= SP1;
                        end else if (char == "$") begin
                            is_mem <= 1'b0;
                            cnt    <= '0;
                            state  <= GRF;
                        end else if (char == "*") begin
                            is_mem <= 1'b1;
                            cnt    <= '0;
                            state  <= ADDR;
                        end
                    end
                    GRF: begin
                        if (is_dec && (cnt < GRF_MAX)) begin
                            grf_acc <= grf_next;
                            cnt     <= cnt + 8'd1;
                            state   <= GRF;
                        end else if ((char == " ") && (cnt != 8'd0)) begin
                            state <= SP2;
                        end else if ((char == "<") && (cnt != 8'd0)) begin
                            state <= EQ;
                        end
                    end
                    ADDR: begin
                        if (is_hex && (cnt < HEX_LEN)) begin
                            addr_acc <= {addr_acc[27:0], digit};
                            cnt      <= cnt + 8'd1;
                            state    <= ADDR;
                        end else if ((char == " ") && (cnt == HEX_LEN)) begin
                            state <= SP2;
                        end else if ((char == "<") && (cnt == HEX_LEN)) begin
                            state <= EQ;
                        end
                    end
                    SP2: begin
                        if (char == " ") begin
                            state <= SP2;
                        end else if (char == "<") begin
                            state <= EQ;
                        end
                    end
                    EQ: begin
                        if (char == "=") begin
                            state <= SP3;
                        end
                    end
                    SP3: begin
                        if (char == " ") begin
                            state <= SP3;
                        end else if (is_hex) begin
                            cnt   <= 8'd1;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        // Data digits are only counted; the eighth moves on to the terminator.
                        if (is_hex) begin
                            cnt   <= cnt + 8'd1;
                            state <= (cnt == HEX_LEN - 8'd1) ? HASH : DATA;
                        end
                    end
                    HASH: begin
                        if (char == "#") begin
                            state       <= DONE;
                            format_type <= is_mem ? 2'd2 : 2'd1;
                            error_code  <= err_next;
                            rec_valid   <= 1'b1;
                            if (rec_count != {CNT_W{1'b1}}) begin
                                rec_count <= rec_count + CNT_W'(1);
                            end
                            if ((err_next != 4'd0) && (err_count != {CNT_W{1'b1}})) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_line_checker.sv
// Bench for trace_line_checker: two instances (lowercase-only and uppercase-hex)
// compared every cycle against a whole-line parsing model, plus literal spot checks.
module tb_trace_line_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [15:0] freq;

    logic [1:0][1:0]  ft;
    logic [1:0][3:0]  ec;
    logic [1:0]       rv;
    logic [1:0][15:0] rc;
    logic [1:0][15:0] erc;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] line_q[$];
    bit         active;
    logic [1:0]  exp_ft[2];
    logic [3:0]  exp_ec[2];
    logic        exp_rv[2];
    logic [15:0] exp_rc[2];
    logic [15:0] exp_erc[2];

    always #5 clk = ~clk;

    trace_line_checker #(.HEX_UPPER(1'b0)) dut (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(ft[0]), .error_code(ec[0]), .rec_valid(rv[0]),
        .rec_count(rc[0]), .err_count(erc[0])
    );

    trace_line_checker #(.HEX_UPPER(1'b1)) dut_up (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(ft[1]), .error_code(ec[1]), .rec_valid(rv[1]),
        .rec_count(rc[1]), .err_count(erc[1])
    );

    function automatic logic [7:0] peek(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'h00;
    endfunction

    function automatic bit is_dec(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic bit is_hex(input logic [7:0] c, input bit upper);
        return is_dec(c) || ((c >= "a") && (c <= "f")) || (upper && (c >= "A") && (c <= "F"));
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (is_dec(c)) return int'(c) - int'("0");
        if (c >= "a") return int'(c) - int'("a") + 10;
        return int'(c) - int'("A") + 10;
    endfunction

    // Whole-line recursive-descent match of one record from '^' to '#'.
    function automatic bit parse_rec(input logic [7:0] q[$], input bit upper,
                                     output int typ, output longint t,
                                     output longint pc, output longint grf,
                                     output longint addr);
        int i = 1;
        int nd = 0;
        longint d = 0;
        typ = 0; t = 0; pc = 0; grf = 0; addr = 0;
        if (peek(q, 0) != "^") return 0;
        while (is_dec(peek(q, i))) begin
            t = t * 10 + longint'(hex_val(peek(q, i)));
            nd++; i++;
        end
        if (nd < 1 || nd > 4) return 0;
        if (peek(q, i) != "@") return 0;
        i++;
        for (int j = 0; j < 8; j++) begin
            if (!is_hex(peek(q, i), upper)) return 0;
            pc = pc * 16 + longint'(hex_val(peek(q, i)));
            i++;
        end
        if (peek(q, i) != ":") return 0;
        i++;
        while (peek(q, i) == " ") i++;
        if (peek(q, i) == "$") begin
            typ = 1; i++; nd = 0;
            while (is_dec(peek(q, i))) begin
                grf = grf * 10 + longint'(hex_val(peek(q, i)));
                nd++; i++;
            end
            if (nd < 1 || nd > 4) return 0;
        end else if (peek(q, i) == "*") begin
            typ = 2; i++;
            for (int j = 0; j < 8; j++) begin
                if (!is_hex(peek(q, i), upper)) return 0;
                addr = addr * 16 + longint'(hex_val(peek(q, i)));
                i++;
            end
        end else begin
            return 0;
        end
        while (peek(q, i) == " ") i++;
        if (peek(q, i) != "<" || peek(q, i + 1) != "=") return 0;
        i += 2;
        while (peek(q, i) == " ") i++;
        for (int j = 0; j < 8; j++) begin
            if (!is_hex(peek(q, i), upper)) return 0;
            d = d * 16 + longint'(hex_val(peek(q, i)));
            i++;
        end
        return (peek(q, i) == "#") && (i == q.size() - 1);
    endfunction

    // Reference model: keep the line since the last caret and judge it when '#' arrives.
    always @(posedge clk) begin
        int typ;
        longint t, pc, grf, addr;
        logic [3:0] e;
        for (int k = 0; k < 2; k++) begin
            exp_ft[k] = 2'd0; exp_ec[k] = 4'd0; exp_rv[k] = 1'b0;
        end
        if (reset) begin
            line_q.delete();
            active = 1'b0;
            for (int k = 0; k < 2; k++) begin
                exp_rc[k] = 16'd0; exp_erc[k] = 16'd0;
            end
        end else if (char == "^") begin
            line_q.delete();
            line_q.push_back(char);
            active = 1'b1;
        end else if (active) begin
            line_q.push_back(char);
            if (char == "#") begin
                active = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (parse_rec(line_q, k == 1, typ, t, pc, grf, addr)) begin
                        e[0] = (t % longint'(freq / 2)) != 0;
                        e[1] = (pc < 64'h3000) || (pc > 64'h6ffc) || (pc % 4 != 0);
                        e[2] = (typ == 2) && ((addr > 64'h2ffc) || (addr % 4 != 0));
                        e[3] = (typ == 1) && (grf >= 32);
                        exp_ft[k] = 2'(typ);
                        exp_ec[k] = e;
                        exp_rv[k] = 1'b1;
                        if (exp_rc[k] != 16'hffff) exp_rc[k]++;
                        if (e != 4'd0 && exp_erc[k] != 16'hffff) exp_erc[k]++;
                    end
                end
            end
        end
    end

    task automatic check_val(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, k, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check_val("model.format_type", k, 32'(ft[k]), 32'(exp_ft[k]));
                check_val("model.error_code", k, 32'(ec[k]), 32'(exp_ec[k]));
                check_val("model.rec_valid", k, 32'(rv[k]), 32'(exp_rv[k]));
                check_val("model.rec_count", k, 32'(rc[k]), 32'(exp_rc[k]));
                check_val("model.err_count", k, 32'(erc[k]), 32'(exp_erc[k]));
            end
        end
    end

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            char = s[i];
        end
    endtask

    // Hand-computed expectations, checked against both the DUT and the model.
    task automatic checkOutput(input string name, input int k, input logic [1:0] f,
                               input logic [3:0] e, input logic [15:0] r, input logic [15:0] er);
        check_val({name, ".format_type"}, k, 32'(ft[k]), 32'(f));
        check_val({name, ".error_code"}, k, 32'(ec[k]), 32'(e));
        check_val({name, ".rec_valid"}, k, 32'(rv[k]), 32'(f != 2'd0));
        check_val({name, ".rec_count"}, k, 32'(rc[k]), 32'(r));
        check_val({name, ".err_count"}, k, 32'(erc[k]), 32'(er));
        check_val({name, ".model_format"}, k, 32'(exp_ft[k]), 32'(f));
        check_val({name, ".model_error"}, k, 32'(exp_ec[k]), 32'(e));
    endtask

    initial begin
        reset = 1'b1;
        char  = 8'h00;
        freq  = 16'd2;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset", 0, 2'd0, 4'h0, 16'd0, 16'd0);
        reset = 1'b0;

        applyStimulus("^242@000030f4: $31 <= 12345678#");
        @(negedge clk); checkOutput("reg_ok", 0, 2'd1, 4'h0, 16'd1, 16'd0);
        char = 8'h00;

        applyStimulus("^242@000030f4: $33 <= 12345678#");
        @(negedge clk); checkOutput("reg_grf_err", 0, 2'd1, 4'h8, 16'd2, 16'd1);
        char = 8'h00;

        applyStimulus("^242@000030f4: $31 <= 123215#");
        @(negedge clk); checkOutput("short_data", 0, 2'd0, 4'h0, 16'd2, 16'd1);
        char = 8'h00;

        applyStimulus("^338@00003130: *00000088 <=   ffffb528#");
        @(negedge clk); checkOutput("mem_ok", 0, 2'd2, 4'h0, 16'd3, 16'd1);
        char = 8'h00;

        freq = 16'd8;
        applyStimulus("^338@00003130: *00000088 <=   ffffb528#");
        @(negedge clk); checkOutput("mem_time_err", 0, 2'd2, 4'h1, 16'd4, 16'd2);
        char = 8'h00;

        freq = 16'd2;
        applyStimulus("^1@00002ffe: *00003000 <= 00000000#");
        @(negedge clk); checkOutput("pc_addr_err", 0, 2'd2, 4'h6, 16'd5, 16'd3);
        char = 8'h00;

        applyStimulus("^338@00003130: *00000088 <= Ffffb528#");
        @(negedge clk);
        checkOutput("upper_lc", 0, 2'd0, 4'h0, 16'd5, 16'd3);
        checkOutput("upper_uc", 1, 2'd2, 4'h0, 16'd6, 16'd3);
        char = 8'h00;

        freq = 16'd16;
        applyStimulus("^9998@00003000:$0031<=00000000#");
        @(negedge clk); checkOutput("max_digits", 0, 2'd1, 4'h1, 16'd6, 16'd4);
        char = 8'h00;

        applyStimulus("^9998@00003000:$00031<=00000000#");
        @(negedge clk); checkOutput("grf_overflow", 0, 2'd0, 4'h0, 16'd6, 16'd4);
        char = 8'h00;

        freq = 16'd2;
        applyStimulus("^242@0000");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid_reset", 0, 2'd0, 4'h0, 16'd0, 16'd0);
        reset = 1'b0;

        applyStimulus("^12345@000030f4: $1 <= 00000000#");
        @(negedge clk); checkOutput("time_overflow", 0, 2'd0, 4'h0, 16'd0, 16'd0);
        char = 8'h00;

        applyStimulus("^242@000030f4: $31 <= 12345678#");
        @(negedge clk); checkOutput("after_reset", 0, 2'd1, 4'h0, 16'd1, 16'd0);
        char = 8'h00;

        applyStimulus("^4@00006ffc:*00002ffc<=0000000a#^5@00007000:$0<=abcdef01#");
        @(negedge clk); checkOutput("back_to_back", 0, 2'd1, 4'h2, 16'd3, 16'd1);
        char = 8'h00;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_line_checker.md
Name: trace_line_checker

Overview:
- Parametrised successor to the single-format CPU trace checker.
- Parses one ASCII character per clock from the simulator trace stream. Validates register-write and memory-write records, and flags semantic errors (time, PC, address, register number).
- Adds configurable field widths, address windows, register count, optional uppercase hex, a one-cycle record strobe and saturating record/error counters.
- Sits beside the CPU testbench output port, feeding pass/fail statistics.

Parameters:
TIME_DIG, 4, max decimal digits of time field (1..TIME_DIG accepted)
GRF_DIG, 4, max decimal digits of register field (1..GRF_DIG accepted)
NUM_REGS, 32, register numbers >= NUM_REGS are errors
PC_LO, 32'h0000_3000, lowest legal PC
PC_HI, 32'h0000_6ffc, highest legal PC
ADDR_HI, 32'h0000_2ffc, highest legal memory address (lowest is 0)
HEX_UPPER, 0, 1 = accept A-F in hex fields; 0 = lowercase a-f only
CNT_W, 16, width of counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
char  in  8  ASCII character sampled every rising edge
freq  in  16  clock-frequency code, power of two >= 2
format_type  out  2  0 invalid/none, 1 register write, 2 memory write
error_code  out  4  bit0 time, bit1 pc, bit2 addr, bit3 grf
rec_valid  out  1  one-cycle pulse when a syntactically valid record completes
rec_count  out  CNT_W  valid records seen, saturating
err_count  out  CNT_W  valid records with nonzero error_code, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high. On reset, all outputs are 0 and the FSM goes to IDLE. Reset mid-record discards the record.
- Record grammar: `^ T @ P : S* ( $ G | * A ) S* <= S* D #`
  - T: 1..TIME_DIG decimal digits.
  - P, A, D: exactly 8 hex digits each.
  - G: 1..GRF_DIG decimal digits.
  - S: space (0x20).
  - `<` and `=` must be adjacent. No other spaces are permitted.
- FSM states: IDLE, TIME, AT, PC, COLON, SP1, GRF, ADDR, SP2, EQ, SP3, DATA, HASH, DONE.
  - Each state counts digits with a per-field counter.
  - Any character not legal in the current state returns the FSM to IDLE.
  - Exception: `^` in any state restarts parsing at TIME, with accumulators cleared.
  - Digit overflow (TIME_DIG+1 or GRF_DIG+1 digits, or a 9th hex digit) → IDLE.
  - Fewer than 8 hex digits followed by a non-hex character → IDLE.
- Accumulators:
  - time: binary, width ceil(log2(10^TIME_DIG)), value = value*10 + digit.
  - grf: same rule, sized for GRF_DIG digits.
  - pc and addr: 32 bits, shifted left by 4 per digit.
  - Data is checked for syntax only and is not stored.
- Completion: when `#` is sampled in HASH, the FSM enters DONE. For exactly that next cycle:
  - format_type = 1 or 2.
  - error_code is valid.
  - rec_valid = 1.
  Otherwise format_type = 0, error_code = 0, rec_valid = 0.
  - From DONE, `^` starts TIME; any other character → IDLE.
- Error bits (evaluated from the completed fields; freq is sampled at completion):
  - bit0 = (time & ((freq>>1)-1)) != 0.
  - bit1 = pc < PC_LO, or pc > PC_HI, or pc[1:0] != 0.
  - bit2 = type 2 and (addr > ADDR_HI or addr[1:0] != 0).
  - bit3 = type 1 and grf >= NUM_REGS.
  - Bits not applicable to the record type are 0.
- Counters:
  - rec_count increments in the DONE cycle.
  - err_count increments in the DONE cycle if error_code != 0.
  - Both hold at all-ones (saturate).
- Back-to-back records: a record with no gap between `#` and the next `^` is legal.

Test Plan:
- freq=2, "^242@000030f4: $31 <= 12345678#" → one cycle later: format_type=1, error_code=0, rec_valid=1, rec_count=1.
- freq=2, same record with $33 → format_type=1, error_code=4'b1000, err_count=1. Same record with data "123215" (6 hex digits) → format_type=0, counters unchanged.
- freq=2, "^338@00003130: *00000088 <=   ffffb528#" → format_type=2, error_code=0. With freq=8 → error_code=4'b0001 (338 mod 4 = 2).
- "^1@00002ffe: *00003000 <= 00000000#" → format_type=2, error_code=4'b0110.
- HEX_UPPER=0: data "Ffffb528" → format_type=0. HEX_UPPER=1: same stimulus → format_type=2.
- Assert reset mid-record, then send "^12345@..." (5 time digits, TIME_DIG=4) → no record. Then send a valid record → rec_count=1, confirming reset cleared the counters and the restart.
